// File: rtl/rv_pkg.sv
// Shared RV32 definitions for the execute-stage helper units.
// div_op_t mirrors funct3[1:0] of the M-extension divide group.
package rv_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } div_state_t;

  localparam logic [31:0] DIV_OVF_DIVIDEND = 32'h8000_0000;

endpackage

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   start, op       request (sampled in IDLE) and funct3[1:0]
//   rs1_data        dividend, rs2_data divisor, rd_in destination index
//   flush           abort the in-flight operation, no write-back
//   busy            high whenever not IDLE
//   done, wb_en     one-cycle write-back strobe (identical)
//   result, rd_out  registered write data / address, held until next DONE
module div_unit
  import rv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  input  logic [4:0]       rd_in,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       rd_out,
  output logic             wb_en
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] OVF_DIVIDEND = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t       r_state, w_next;
  div_op_t          r_op;
  logic             r_neg_q, r_neg_r;
  logic [WIDTH-1:0] r_rem, r_quo, r_dvsr, r_result;
  logic [4:0]       r_rd, r_rd_out;
  logic [CW-1:0]    r_cnt;

  logic             w_signed, w_a_neg, w_b_neg, w_div0, w_ovf, w_special, w_last;
  logic [WIDTH-1:0] w_a_mag, w_b_mag, w_quo_fix, w_rem_fix, w_special_res;
  logic [WIDTH:0]   w_shift, w_trial;

  // op[0]=0 selects the signed variants (DIV, REM)
  assign w_signed  = ~op[0];
  assign w_a_neg   = w_signed & rs1_data[WIDTH-1];
  assign w_b_neg   = w_signed & rs2_data[WIDTH-1];
  assign w_a_mag   = w_a_neg ? -rs1_data : rs1_data;
  assign w_b_mag   = w_b_neg ? -rs2_data : rs2_data;
  assign w_div0    = (rs2_data == '0);
  assign w_ovf     = w_signed & (rs1_data == OVF_DIVIDEND) & (rs2_data == '1);
  assign w_special = w_div0 | w_ovf;

  always_comb begin
    w_special_res = '0;
    if (w_div0)
      w_special_res = op[1] ? rs1_data : '1;
    else
      w_special_res = op[1] ? '0 : OVF_DIVIDEND;
  end

  // Partial remainder is always below the divisor, so the shifted value
  // fits in WIDTH+1 bits and the trial difference sign is its MSB.
  assign w_shift   = {r_rem, r_quo[WIDTH-1]};
  assign w_trial   = w_shift - {1'b0, r_dvsr};
  assign w_last    = (r_cnt == CW'(WIDTH - 1));

  assign w_quo_fix = r_neg_q ? -r_quo : r_quo;
  assign w_rem_fix = r_neg_r ? -r_rem : r_rem;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = w_special ? DONE : CALC;
      CALC:    if (w_last) w_next = FIX;
      FIX:     w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (flush) w_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op     <= DIV;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvsr   <= '0;
      r_cnt    <= '0;
      r_rd     <= '0;
      r_rd_out <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start && !flush) begin
            r_op    <= div_op_t'(op);
            r_rd    <= rd_in;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_quo   <= w_a_mag;
            r_dvsr  <= w_b_mag;
            r_rem   <= '0;
            r_cnt   <= '0;
            // Special cases skip CALC/FIX, so the write-back registers load now
            if (w_special) begin
              r_result <= w_special_res;
              r_rd_out <= rd_in;
            end
          end
        end
        CALC: begin
          r_cnt <= r_cnt + 1'b1;
          if (!w_trial[WIDTH]) begin
            r_rem <= w_trial[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], 1'b1};
          end else begin
            r_rem <= w_shift[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], 1'b0};
          end
        end
        FIX: begin
          if (!flush) begin
            r_result <= (r_op inside {REM, REMU}) ? w_rem_fix : w_quo_fix;
            r_rd_out <= r_rd;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy   = (r_state != IDLE);
  assign done   = (r_state == DONE);
  assign wb_en  = (r_state == DONE);
  assign result = r_result;
  assign rd_out = r_rd_out;

endmodule

// File: tb/tb_div_unit.sv
// Directed and reference-model checks for div_unit at WIDTH=32.
module tb_div_unit;
  import rv_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [1:0]  op;
  logic [31:0] rs1, rs2;
  logic [4:0]  rd_in;
  logic        busy, done, wb_en;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs1_data(rs1), .rs2_data(rs2), .rd_in(rd_in), .flush(flush),
    .busy(busy), .done(done), .result(result), .rd_out(rd_out), .wb_en(wb_en)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0]) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return o[1] ? r[31:0] : q[31:0];
  endfunction

  function automatic int ref_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!o[0] && a == DIV_OVF_DIVIDEND && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Issues one request (start high in cycle N), then runs ncyc cycles.
  // ks1/ks2/kfl/krs: cycle offsets where start/flush/reset are driven high.
  // kobs: cycle offset where busy/result/rd_out are captured.
  task automatic run_op(
    input  logic [1:0]  i_op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
    input  int ks1, input int ks2, input int kfl, input int krs, input int kobs, input int ncyc,
    output int lat, output int ndone, output logic [31:0] res, output logic [4:0] rdo,
    output logic wbe, output int wb_bad,
    output logic obs_busy, output logic [31:0] obs_res, output logic [4:0] obs_rd);
    @(negedge clk);
    op = i_op; rs1 = a; rs2 = b; rd_in = rd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Operands change after the request so a spurious re-start is visible
    op = 2'b01; rs1 = 32'd1000; rs2 = 32'd1; rd_in = 5'd31;
    lat = -1; ndone = 0; wb_bad = 0; res = '0; rdo = '0; wbe = 1'b0;
    obs_busy = 1'bx; obs_res = 'x; obs_rd = 'x;
    for (int k = 1; k <= ncyc; k++) begin
      if (k == kobs) begin
        obs_busy = busy; obs_res = result; obs_rd = rd_out;
      end
      if (done) begin
        ndone++;
        if (lat < 0) begin
          lat = k; res = result; rdo = rd_out; wbe = wb_en;
        end
      end
      if (wb_en !== done) wb_bad++;
      start = (k == ks1) || (k == ks2);
      flush = (k == kfl);
      reset = (k == krs);
      @(posedge clk); #1;
    end
    start = 1'b0; flush = 1'b0; reset = 1'b0;
  endtask

  int          lat, ndone, wb_bad;
  logic [31:0] res, obs_res;
  logic [4:0]  rdo, obs_rd;
  logic        wbe, obs_busy;

  initial begin
    tbl[0]  = '{2'b00, 32'd20,         32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFFA, 34};
    tbl[1]  = '{2'b10, 32'hFFFF_FFEC,  32'd3,         5'd6,  32'hFFFF_FFFE, 34};
    tbl[2]  = '{2'b11, 32'hFFFF_FFFF,  32'h10,        5'd7,  32'h0000_000F, 34};
    tbl[3]  = '{2'b01, 32'hFFFF_FFFF,  32'd2,         5'd8,  32'h7FFF_FFFF, 34};
    tbl[4]  = '{2'b00, 32'd7,          32'd0,         5'd9,  32'hFFFF_FFFF, 1};
    tbl[5]  = '{2'b10, 32'd7,          32'd0,         5'd10, 32'd7,         1};
    tbl[6]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1};
    tbl[7]  = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 32'd0,         1};
    tbl[8]  = '{2'b01, 32'd7,          32'd0,         5'd13, 32'hFFFF_FFFF, 1};
    tbl[9]  = '{2'b11, 32'hDEAD_BEEF,  32'd0,         5'd14, 32'hDEAD_BEEF, 1};
    tbl[10] = '{2'b00, 32'hFFFF_FFF9,  32'd2,         5'd15, 32'hFFFF_FFFD, 34};
    tbl[11] = '{2'b10, 32'hFFFF_FFF9,  32'd2,         5'd16, 32'hFFFF_FFFF, 34};
    tbl[12] = '{2'b01, 32'h8000_0000,  32'hFFFF_FFFF, 5'd17, 32'd0,         34};
    tbl[13] = '{2'b11, 32'h8000_0000,  32'hFFFF_FFFF, 5'd18, 32'h8000_0000, 34};
    tbl[14] = '{2'b00, 32'd7,          32'hFFFF_FFFE, 5'd0,  32'hFFFF_FFFD, 34};
    tbl[15] = '{2'b10, 32'd7,          32'hFFFF_FFFE, 5'd19, 32'd1,         34};

    reset = 1'b1; start = 1'b0; flush = 1'b0;
    op = '0; rs1 = '0; rs2 = '0; rd_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy",   64'(busy),   64'd0);
    chk("reset_done",   64'(done),   64'd0);
    chk("reset_wb_en",  64'(wb_en),  64'd0);
    chk("reset_result", 64'(result), 64'd0);
    chk("reset_rd_out", 64'(rd_out), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].rd, 0, 0, 0, 0, 1, 40,
             lat, ndone, res, rdo, wbe, wb_bad, obs_busy, obs_res, obs_rd);
      chk($sformatf("vec%0d_result", i),  64'(res),    64'(tbl[i].exp));
      chk($sformatf("vec%0d_rd_out", i),  64'(rdo),    64'(tbl[i].rd));
      chk($sformatf("vec%0d_latency", i), 64'(lat),    64'(tbl[i].lat));
      chk($sformatf("vec%0d_ndone", i),   64'(ndone),  64'd1);
      chk($sformatf("vec%0d_wb_en", i),   64'(wbe),    64'd1);
      chk($sformatf("vec%0d_wb_eq", i),   64'(wb_bad), 64'd0);
      if (tbl[i].lat == 34)
        chk($sformatf("vec%0d_busy_n1", i), 64'(obs_busy), 64'd1);
    end

    // start pulses while busy are ignored
    run_op(2'b00, 32'd100, 32'd9, 5'd3, 5, 20, 0, 0, 0, 40,
           lat, ndone, res, rdo, wbe, wb_bad, obs_busy, obs_res, obs_rd);
    chk("busy_start_ndone",  64'(ndone), 64'd1);
    chk("busy_start_result", 64'(res),   64'd11);
    chk("busy_start_rd",     64'(rdo),   64'd3);
    chk("busy_start_lat",    64'(lat),   64'd34);

    // flush mid-CALC aborts without write-back
    run_op(2'b01, 32'd500, 32'd3, 5'd4, 0, 0, 10, 0, 11, 40,
           lat, ndone, res, rdo, wbe, wb_bad, obs_busy, obs_res, obs_rd);
    chk("flush_busy_n11", 64'(obs_busy), 64'd0);
    chk("flush_ndone",    64'(ndone),    64'd0);
    chk("flush_result_hold", 64'(obs_res), 64'd11);
    run_op(2'b01, 32'd100, 32'd7, 5'd21, 0, 0, 0, 0, 0, 40,
           lat, ndone, res, rdo, wbe, wb_bad, obs_busy, obs_res, obs_rd);
    chk("post_flush_result", 64'(res), 64'd14);
    chk("post_flush_rd",     64'(rdo), 64'd21);
    chk("post_flush_lat",    64'(lat), 64'd34);

    // reset mid-CALC
    run_op(2'b00, 32'd1234, 32'd5, 5'd22, 0, 0, 0, 15, 16, 40,
           lat, ndone, res, rdo, wbe, wb_bad, obs_busy, obs_res, obs_rd);
    chk("midreset_busy",   64'(obs_busy), 64'd0);
    chk("midreset_result", 64'(obs_res),  64'd0);
    chk("midreset_rd",     64'(obs_rd),   64'd0);
    chk("midreset_ndone",  64'(ndone),    64'd0);

    // random sweep against the reference model
    for (int i = 0; i < 24; i++) begin
      logic [1:0]  r_op;
      logic [31:0] r_a, r_b;
      logic [4:0]  r_rd;
      r_op = 2'($urandom_range(0, 3));
      r_a  = $urandom;
      case ($urandom_range(0, 3))
        0:       r_b = 32'($urandom_range(0, 15));
        1:       r_b = -32'($urandom_range(1, 15));
        default: r_b = $urandom >> $urandom_range(0, 24);
      endcase
      r_rd = (i % 4 == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      run_op(r_op, r_a, r_b, r_rd, 0, 0, 0, 0, 0, 40,
             lat, ndone, res, rdo, wbe, wb_bad, obs_busy, obs_res, obs_rd);
      chk($sformatf("rnd%0d_result op%0d 0x%0h/0x%0h", i, r_op, r_a, r_b),
          64'(res), 64'(ref_res(r_op, r_a, r_b)));
      chk($sformatf("rnd%0d_rd_out", i),  64'(rdo),   64'(r_rd));
      chk($sformatf("rnd%0d_latency", i), 64'(lat),   64'(ref_lat(r_op, r_a, r_b)));
      chk($sformatf("rnd%0d_ndone", i),   64'(ndone), 64'd1);
      chk($sformatf("rnd%0d_wb_en", i),   64'(wbe),   64'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative RV32M divide/remainder unit sitting between the register file read ports and its write port. It consumes the rs1/rs2 operands read from the register file, runs a radix-2 restoring division over WIDTH cycles, and returns the quotient or remainder with a one-cycle write-back strobe that drives the register file write port (write_enable, A3, WD). The pipeline stalls on busy while a division is in flight.

## Interface
- WIDTH, default 32: operand/result width; iteration count equals WIDTH.
- clk  input  1  rising-edge clock; one clock domain.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- op  input  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- rs1_data  input  WIDTH  dividend (register file RD1).
- rs2_data  input  WIDTH  divisor (register file RD2).
- rd_in  input  5  destination register index.
- flush  input  1  synchronous abort of the in-flight operation.
- busy  output  1  high in every non-IDLE state.
- done  output  1  one-cycle pulse; result and rd_out valid.
- result  output  WIDTH  quotient or remainder; to register file WD.
- rd_out  output  5  latched rd_in; to register file A3.
- wb_en  output  1  equals done; to register file write_enable (x0 suppression is the register file's job).

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE, start=1: latch op, rd_in, operand signs; magnitudes |rs1|, |rs2| for signed ops, raw values for unsigned; clear remainder accumulator and counter. Next state CALC, or DONE for a special case.
- Special cases, resolved at start with result preloaded:
  - divisor 0: quotient all ones, remainder = rs1_data (both signed and unsigned).
  - signed overflow (rs1 = 0x8000_0000, rs2 = 0xFFFF_FFFF): quotient 0x8000_0000, remainder 0.
- CALC, once per cycle:
  - shift {rem, quo} left one bit.
  - trial-subtract the divisor magnitude in WIDTH+1 bits; if non-negative, keep the difference and set quotient LSB.
  - after WIDTH iterations go to FIX.
- FIX: negate the quotient if operand signs differ (signed DIV); negate the remainder if the dividend was negative (signed REM); select quotient or remainder by op[1]. Next state DONE.
- DONE: done=1, wb_en=1 for exactly one cycle; start ignored; next state IDLE.
- start while busy: ignored, no queuing.
- flush in any state: next state IDLE, no done; a start in the same cycle as flush is ignored.
- reset: highest priority over flush and start, in any state, including mid-CALC.

## Timing
- Reset values: busy=0, done=0, wb_en=0, result=0, rd_out=0; state IDLE.
- start high in cycle N, normal path: busy high from N+1; done high in cycle N+WIDTH+2 (N+34 at WIDTH=32); IDLE in N+WIDTH+3.
- Special case: done high in cycle N+1; IDLE in N+2.
- result and rd_out are registered and hold their value after done until the next DONE; the consumer samples only while done=1.
- Back-to-back: the earliest next accepted start is the first IDLE cycle after DONE.
- No combinational path from any input to any output.

## Structure
- Shared package rv_pkg:
  - div_op_t enum: DIV, DIVU, REM, REMU.
  - div_state_t enum: IDLE, CALC, FIX, DONE.
  - constant DIV_OVF_DIVIDEND = 0x8000_0000.
- Single module, no sub-module; the counter width is $clog2(WIDTH)+1.

## Test plan
- DIV 20 / -3, rd_in=5 → done in cycle N+34, result 0xFFFF_FFFA (-6), rd_out=5, wb_en=1 for one cycle.
- REM -20 / 3 → result 0xFFFF_FFFE (-2); REMU 0xFFFF_FFFF / 0x10 → 0xF; DIVU 0xFFFF_FFFF / 2 → 0x7FFF_FFFF.
- DIV 7 / 0 → done in N+1, result 0xFFFF_FFFF; REM 7 / 0 → result 7; DIV 0x8000_0000 / -1 → 0x8000_0000; REM of the same → 0.
- start pulsed in cycles N+5 and N+20 during a busy operation → ignored; exactly one done, with the original result.
- flush in cycle N+10 → IDLE at N+11, done never asserted; a new DIVU 100 / 7 issued afterwards → 14.
- reset in cycle N+15 → next cycle busy=0, result=0, rd_out=0; then a random signed/unsigned sweep checked against a reference model, including x0 as destination (wb_en still pulses).
